// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder sitting at the target end of the MEM-stage load/store
// request interface of the pipelined MIPS datapath. One word request at a
// time is accepted through a valid/ready handshake. After WAIT_CYCLES wait
// states a single-cycle response carries the load data and an error flag.
// The response path never applies backpressure; the MEM stage stalls on a
// deasserted req_ready and on its own pending response.
//
// Parameters:
//   ADDR_WIDTH   log2 of the memory depth in 32-bit words
//   DATA_WIDTH   data word width
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   req_valid    MEM stage presents a request
//   req_ready    responder can accept a request this cycle
//   req_write    1 = store (sw), 0 = load (lw)
//   req_addr     byte address
//   req_wdata    store data
//   resp_valid   one-cycle response strobe
//   resp_rdata   load data; 0 for stores and errored accesses
//   resp_err     misaligned or out-of-range access, qualified by resp_valid
//   busy         high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  busy
);

   localparam int         Depth    = 1 << ADDR_WIDTH;
   localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                  state_q;
   logic [3:0]              cnt_q;
   logic                    write_q;
   logic [31:0]             addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    req_ready_q;
   logic                    resp_valid_q;
   logic [DATA_WIDTH-1:0]   resp_rdata_q;
   logic                    resp_err_q;
   logic                    busy_q;

   logic [DATA_WIDTH-1:0]   mem [Depth];

   logic                    accept;
   logic                    commit;
   logic                    cWrite;
   logic [31:0]             cAddr;
   logic [DATA_WIDTH-1:0]   cWdata;
   logic [ADDR_WIDTH-1:0]   cIdx;
   logic                    err_d;
   logic [DATA_WIDTH-1:0]   rdata_d;

   assign accept = (state_q == IDLE) && req_valid;

   // The commit edge is the one entering RESP. With zero wait states that is
   // the acceptance edge itself, so the live request is used instead of the
   // latched copy; the request inputs are only looked at while idle.
   always_comb begin
      cWrite = write_q;
      cAddr  = addr_q;
      cWdata = wdata_q;
      if (state_q == IDLE) begin
         cWrite = req_write;
         cAddr  = req_addr;
         cWdata = req_wdata;
      end
   end

   assign commit = (accept && (WAIT_CYCLES == 0)) ||
                   ((state_q == WAIT) && (cnt_q == 4'd1));

   // Word index plus the error decode: low byte-offset bits must be zero and
   // nothing may be set above the implemented word range.
   assign cIdx    = cAddr[ADDR_WIDTH+1:2];
   assign err_d   = (|cAddr[1:0]) || (|cAddr[31:ADDR_WIDTH+2]);
   assign rdata_d = (err_d || cWrite) ? '0 : mem[cIdx];

   // Storage array is deliberately not reset. The reset term guards the
   // zero-wait-state case where a request could be seen while reset is held.
   always_ff @(posedge clk) begin
      if (commit && cWrite && !err_d && reset) begin
         mem[cIdx] <= cWdata;
      end
   end

   // Request/response FSM with all outputs registered. Reset during WAIT
   // simply lands back in IDLE, so an uncommitted store is lost and no
   // response is produced.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  write_q     <= req_write;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_rdata_q <= rdata_d;
                     resp_err_q   <= err_d;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= WaitInit;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd1) begin
                  state_q      <= RESP;
                  cnt_q        <= '0;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= rdata_d;
                  resp_err_q   <= err_d;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               busy_q       <= 1'b0;
            end
            default: begin
               state_q      <= IDLE;
               cnt_q        <= '0;
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Instance A uses two wait states and
// instance B uses none. Each accepted request pushes its expected response
// (data, error flag, edge at which the response appears) onto a per-instance
// queue; a monitor pops and compares whenever resp_valid is seen.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          respEdge;
   } exp_t;

   logic        clk;
   logic        reset;

   logic        validA, writeA, readyA, respValidA, errA, busyA;
   logic [31:0] addrA, wdataA, rdataA;
   logic        validB, writeB, readyB, respValidB, errB, busyB;
   logic [31:0] addrB, wdataB, rdataB;

   int          edgeCount;
   int          vectors;
   int          miscompares;
   exp_t        sbA[$];
   exp_t        sbB[$];

   dmem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dutA (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (validA),
      .req_ready  (readyA),
      .req_write  (writeA),
      .req_addr   (addrA),
      .req_wdata  (wdataA),
      .resp_valid (respValidA),
      .resp_rdata (rdataA),
      .resp_err   (errA),
      .busy       (busyA)
   );

   dmem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dutB (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (validB),
      .req_ready  (readyB),
      .req_write  (writeB),
      .req_addr   (addrB),
      .req_wdata  (wdataB),
      .resp_valid (respValidB),
      .resp_rdata (rdataB),
      .resp_err   (errB),
      .busy       (busyB)
   );

   // Free-running clock and rising-edge counter used for latency checks.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial edgeCount = 0;
   always @(posedge clk) edgeCount <= edgeCount + 1;

   // Single comparison point: every check funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic timeoutFail(input string tag);
      vectors++;
      miscompares++;
      $error("[TB] FAIL %s observed=timeout expected=event", tag);
   endtask

   // Scoreboard monitors: pop the oldest expectation on each response strobe.
   always @(negedge clk) begin
      if (respValidA === 1'b1) begin
         if (sbA.size() == 0) begin
            timeoutFail("unexpectedRespA");
         end else begin
            exp_t e;
            e = sbA.pop_front();
            checkOutput("rdataA", rdataA, e.rdata);
            checkOutput("errA", 32'(errA), 32'(e.err));
            checkOutput("latencyA", 32'(edgeCount), 32'(e.respEdge));
         end
      end
   end

   always @(negedge clk) begin
      if (respValidB === 1'b1) begin
         if (sbB.size() == 0) begin
            timeoutFail("unexpectedRespB");
         end else begin
            exp_t e;
            e = sbB.pop_front();
            checkOutput("rdataB", rdataB, e.rdata);
            checkOutput("errB", 32'(errB), 32'(e.err));
            checkOutput("latencyB", 32'(edgeCount), 32'(e.respEdge));
         end
      end
   end

   // Drive one request into instance A, wait for it to be accepted and queue
   // its expected response two edges after acceptance.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                input logic [31:0] expRdata,
                                input logic expErr, output int acc);
      int n;
      @(negedge clk);
      validA = 1'b1;
      writeA = wr;
      addrA  = addr;
      wdataA = wdata;
      n = 0;
      while (readyA !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      acc = -1;
      if (n >= 20) begin
         timeoutFail("acceptA");
         validA = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         acc = edgeCount;
         sbA.push_back('{rdata: expRdata, err: expErr, respEdge: acc + 2});
         validA = 1'b0;
         wdataA = 32'hxxxx_xxxx;
         @(negedge clk);
         checkOutput("readyLowA", 32'(readyA), 32'd0);
         checkOutput("busyHighA", 32'(busyA), 32'd1);
      end
   endtask

   // Wait for instance A's response, then confirm it is back to idle.
   task automatic waitRespA(input string tag);
      int n;
      n = 0;
      while (respValidA !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         timeoutFail(tag);
      end else begin
         @(negedge clk);
         checkOutput("readyBackA", 32'(readyA), 32'd1);
         checkOutput("respPulseA", 32'(respValidA), 32'd0);
         checkOutput("busyLowA", 32'(busyA), 32'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc, acc1, acc2, n;

      vectors     = 0;
      miscompares = 0;
      reset  = 1'b0;
      validA = 1'b0; writeA = 1'b0; addrA = '0; wdataA = '0;
      validB = 1'b0; writeB = 1'b0; addrB = '0; wdataB = '0;

      // Reset values while reset is held.
      repeat (2) @(negedge clk);
      checkOutput("rstReadyA", 32'(readyA), 32'd1);
      checkOutput("rstValidA", 32'(respValidA), 32'd0);
      checkOutput("rstBusyA", 32'(busyA), 32'd0);
      checkOutput("rstRdataA", rdataA, 32'd0);
      checkOutput("rstErrA", 32'(errA), 32'd0);
      checkOutput("rstReadyB", 32'(readyB), 32'd1);
      reset = 1'b1;

      // Store then load the same word.
      applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, acc);
      waitRespA("respSt10");
      applyStimulus(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, acc);
      waitRespA("respLd10");

      // Error cases: misaligned store must not touch memory, out-of-range.
      applyStimulus(1'b1, 32'h0000_0013, 32'h1234_5678, 32'h0, 1'b1, acc);
      waitRespA("respStMis");
      applyStimulus(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, acc);
      waitRespA("respLd10b");
      applyStimulus(1'b0, 32'h0000_0400, 32'h0, 32'h0, 1'b1, acc);
      waitRespA("respLdOor");
      applyStimulus(1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b1, acc);
      waitRespA("respLdHigh");
      applyStimulus(1'b0, 32'h0000_0012, 32'h0, 32'h0, 1'b1, acc);
      waitRespA("respLdMis");

      // Highest implemented word.
      applyStimulus(1'b1, 32'h0000_03FC, 32'hA5A5_0001, 32'h0, 1'b0, acc);
      waitRespA("respSt3fc");
      applyStimulus(1'b0, 32'h0000_03FC, 32'h0, 32'hA5A5_0001, 1'b0, acc);
      waitRespA("respLd3fc");

      // Back-to-back stores with req_valid held high.
      @(negedge clk);
      validA = 1'b1; writeA = 1'b1; addrA = 32'h0; wdataA = 32'h0000_AAAA;
      checkOutput("b2bIdleA", 32'(readyA), 32'd1);
      @(posedge clk);
      #1;
      acc1 = edgeCount;
      sbA.push_back('{rdata: 32'h0, err: 1'b0, respEdge: acc1 + 2});
      addrA = 32'h4; wdataA = 32'h0000_BBBB;
      @(negedge clk);
      n = 0;
      while (readyA !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         timeoutFail("b2bAcceptA");
      end else begin
         @(posedge clk);
         #1;
         acc2 = edgeCount;
         sbA.push_back('{rdata: 32'h0, err: 1'b0, respEdge: acc2 + 2});
         checkOutput("b2bSpacingA", 32'(acc2 - acc1), 32'd4);
      end
      validA = 1'b0;
      @(negedge clk);
      waitRespA("respB2b");
      applyStimulus(1'b0, 32'h0000_0000, 32'h0, 32'h0000_AAAA, 1'b0, acc);
      waitRespA("respLd0");
      applyStimulus(1'b0, 32'h0000_0004, 32'h0, 32'h0000_BBBB, 1'b0, acc);
      waitRespA("respLd4");

      // Reset during WAIT drops the store and the response.
      applyStimulus(1'b1, 32'h0000_0020, 32'h1111_1111, 32'h0, 1'b0, acc);
      waitRespA("respSt20");
      applyStimulus(1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0, acc);
      waitRespA("respLd20");
      @(negedge clk);
      validA = 1'b1; writeA = 1'b1; addrA = 32'h20; wdataA = 32'hCAFE_F00D;
      checkOutput("abortIdleA", 32'(readyA), 32'd1);
      @(posedge clk);
      #1;
      validA = 1'b0;
      @(negedge clk);
      checkOutput("abortBusyA", 32'(busyA), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("abortReadyA", 32'(readyA), 32'd1);
      checkOutput("abortValidA", 32'(respValidA), 32'd0);
      checkOutput("abortBusyLowA", 32'(busyA), 32'd0);
      checkOutput("abortRdataA", rdataA, 32'd0);
      checkOutput("abortErrA", 32'(errA), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("abortNoRespA", 32'(respValidA), 32'd0);
      applyStimulus(1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0, acc);
      waitRespA("respLd20b");

      // Zero wait states: store then load held back-to-back on instance B.
      @(negedge clk);
      validB = 1'b1; writeB = 1'b1; addrB = 32'h8; wdataB = 32'h55AA_55AA;
      checkOutput("idleB", 32'(readyB), 32'd1);
      @(posedge clk);
      #1;
      acc1 = edgeCount;
      sbB.push_back('{rdata: 32'h0, err: 1'b0, respEdge: acc1});
      writeB = 1'b0; wdataB = 32'h0;
      @(negedge clk);
      checkOutput("readyLowB", 32'(readyB), 32'd0);
      n = 0;
      while (readyB !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         timeoutFail("acceptB");
      end else begin
         @(posedge clk);
         #1;
         acc2 = edgeCount;
         sbB.push_back('{rdata: 32'h55AA_55AA, err: 1'b0, respEdge: acc2});
         checkOutput("spacingB", 32'(acc2 - acc1), 32'd2);
      end
      validB = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("readyEndB", 32'(readyB), 32'd1);

      // Every queued response must have arrived.
      repeat (4) @(negedge clk);
      checkOutput("drainA", 32'(sbA.size()), 32'd0);
      checkOutput("drainB", 32'(sbB.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
